result_buffer: RTL and testbench
================================

# result_buffer

Result capture stage directly downstream of the series-evaluation controller/datapath pair. It samples the datapath result register on each rising edge of the controller's `done` and queues the word with a sequence tag in a small first-word-fall-through FIFO. Results are presented to the consumer over a valid/ready handshake. `full` is fed back so the top level can hold `start` while no slot is free.

## Interface
Parameters:
- `WIDTH`, 16: result word width; must match the datapath `r` register.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `done`  in  1: controller done level.
- `r_in`  in  WIDTH: datapath result; valid whenever `done` is high.
- `clear`  in  1: synchronous flush.
- `out_data`  out  WIDTH: head-of-queue result.
- `out_tag`  out  8: sequence tag of the head entry.
- `out_valid`  out  1: head entry present.
- `out_ready`  in  1: consumer accepts the head entry.
- `full`  out  1: occupancy == DEPTH.
- `empty`  out  1: occupancy == 0.
- `count`  out  $clog2(DEPTH)+1: occupancy.
- `overflow`  out  1: sticky; set when a result was dropped.

## Operation
- Edge detect:
  - `done_d` register; reset value 1.
  - Capture request `cap = done & ~done_d`.
  - A `done` held high out of reset (controller idle) produces no capture.
  - A `done` pulse held several cycles produces exactly one capture.
- Pop: `pop = out_valid & out_ready`.
- Write rule: on `cap`, write `{r_in, tag_cnt}` at `wr_ptr` if `count < DEPTH`, or if `count == DEPTH` and `pop` is high in the same cycle.
  - Otherwise drop the result and set `overflow`.
  - A dropped result does not advance `tag_cnt`.
- `tag_cnt`: 8-bit, increments per accepted write, wraps 255 -> 0.
- Pointers: `$clog2(DEPTH)` bits each; they wrap naturally.
- `count` update:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous write and pop, including at empty and at full.
- Output is first-word-fall-through:
  - `out_data` and `out_tag` are driven combinationally from `mem[rd_ptr]`.
  - `out_valid = ~empty`.
  - `out_data` is undefined when `out_valid` is low; checkers must not compare it then.
- Simultaneous write and pop at `count == 0`: not possible, because `out_valid` is low.
- `clear`:
  - Zeroes the pointers, `count`, `tag_cnt` and `overflow`.
  - Loads `done_d <= done`, so a `done` that is already high is not captured.
  - Has priority over `cap` and `pop` in the same cycle.
- Reset values:
  - `count` = 0, `empty` = 1, `full` = 0, `out_valid` = 0, `overflow` = 0.
  - `tag_cnt` = 0, pointers = 0, `done_d` = 1.
  - Memory contents are not reset.
- Reset asserted mid-operation: all of the above apply immediately, asynchronously; queued results are lost.

## Timing
- Capture latency: `done` rises before edge k, the entry is written at edge k, and `out_valid` is high after edge k (1 cycle).
- `full` and `count` reflect the write after the same edge k.
- Pop: `out_valid & out_ready` sampled at edge k; the next entry (or `out_valid` low) is visible after edge k.
- Back-to-back `done` rising edges, minimum 2 cycles apart (low for at least one cycle), are each captured.
- Combinational paths: `out_ready` to any output has none; `r_in` to any output has none.

## Configuration
- `RESULT_BUF_OVF_CNT_EN` defined:
  - Adds output port `ovf_count` (out, 8 bits).
  - `ovf_count` counts dropped results and saturates at 255.
  - `ovf_count` is reset to 0 by `rst` and by `clear`.
- Not defined: the port is absent; only the sticky `overflow` reports drops.

## Test plan
- Reset with `done` = 1 held, release `rst` → no capture; `count` = 0, `out_valid` = 0.
- `done` low, `r_in` = 16'h1234, `done` rises for 3 cycles, `out_ready` = 0 → one entry; `out_data` = 16'h1234, `out_tag` = 0, `count` = 1, `out_valid` high 1 cycle after the rise.
- Five captures (values 1..5) with `out_ready` = 0, `DEPTH` = 4:
  - Result: `full` = 1, `overflow` = 1; with the macro, `ovf_count` = 1.
  - Draining yields 1, 2, 3, 4 with tags 0..3.
- At full, a capture coincident with a pop is accepted: `count` stays 4, `overflow` stays 0, and the new tag continues the sequence.
- 260 capture/pop pairs → `out_tag` wraps 255 → 0 → 1, and `count` never exceeds 1.
- `clear` asserted together with a capture at `count` = 2 → `count` = 0, `overflow` = 0, `out_valid` = 0, no entry written; the next capture gets tag 0.

Source files
------------

// File: rtl/result_buffer.sv
// Captures the datapath result on each rising edge of done into a FWFT FIFO with an 8-bit sequence tag; 1-cycle capture latency.
// Drops the result and sets sticky overflow when full without a same-cycle pop; RESULT_BUF_OVF_CNT_EN adds a saturating ovf_count port.
module result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [WIDTH-1:0]         r_in,
  input  logic                     clear,
  output logic [WIDTH-1:0]         out_data,
  output logic [7:0]               out_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef RESULT_BUF_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH+7:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [7:0]       tag_cnt;
  logic             done_d;
  logic             cap;
  logic             pop;
  logic             wr_en;
  logic             drop;

  assign cap       = done & ~done_d;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  // A pop at full frees the slot in the same cycle, so the capture still fits.
  assign wr_en     = cap & (~full | pop);
  assign drop      = cap & full & ~pop;

  assign {out_data, out_tag} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr] <= {r_in, tag_cnt};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_d   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      // Re-arm the edge detector from the current level so a held done is ignored.
      done_d   <= done;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tag_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      done_d <= done;
      if (wr_en) begin
        wr_ptr  <= wr_ptr + AW'(1);
        tag_cnt <= tag_cnt + 8'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef RESULT_BUF_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_count <= '0;
    end else if (clear) begin
      ovf_count <= '0;
    end else if (drop && ovf_count != 8'hFF) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_result_buffer.sv
// Bench for result_buffer: directed scenarios plus random traffic, checked against a queue-based reference model.
module tb_result_buffer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             done;
  logic [WIDTH-1:0] r_in;
  logic             clear;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_tag;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             overflow;
`ifdef RESULT_BUF_OVF_CNT_EN
  logic [7:0]       ovf_count;
`endif

  result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .r_in      (r_in),
    .clear     (clear),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
`ifdef RESULT_BUF_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of {data, tag}, plus the previous done level.
  logic [23:0] m_q[$];
  int          m_tag;
  bit          m_prev;
  bit          m_ovf;
  int          m_ovfcnt;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tag    = 0;
    m_prev   = 1'b1;
    m_ovf    = 1'b0;
    m_ovfcnt = 0;
  endtask

  task automatic model_edge();
    bit rise;
    bit popping;
    bit acc;
    if (!rst) begin
      model_reset();
    end else if (clear) begin
      model_reset();
      m_prev = done;
    end else begin
      rise    = done && !m_prev;
      popping = (m_q.size() > 0) && out_ready;
      acc     = rise && ((m_q.size() < DEPTH) || popping);
      if (popping) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back({r_in, m_tag[7:0]});
        m_tag = (m_tag + 1) % 256;
      end else if (rise) begin
        m_ovf = 1'b1;
        if (m_ovfcnt < 255) m_ovfcnt++;
      end
      m_prev = done;
    end
  endtask

  task automatic check_model();
    chk("count", count, m_q.size());
    chk("empty", empty, m_q.size() == 0);
    chk("full", full, m_q.size() == DEPTH);
    chk("out_valid", out_valid, m_q.size() != 0);
    chk("overflow", overflow, m_ovf);
    if (m_q.size() > 0) begin
      chk("out_data", out_data, m_q[0][23:8]);
      chk("out_tag", out_tag, m_q[0][7:0]);
    end
`ifdef RESULT_BUF_OVF_CNT_EN
    chk("ovf_count", ovf_count, m_ovfcnt);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic capture(input logic [WIDTH-1:0] v);
    r_in = v;
    done = 1'b1;
    step();
    done = 1'b0;
    step();
  endtask

  initial begin
    rst       = 1'b0;
    done      = 1'b1;
    r_in      = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #2;
    check_model();

    // Reset released with done already high: no capture.
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("idle_no_cap", count, 0);

    // Single capture from a done pulse held three cycles.
    done = 1'b0;
    step();
    r_in = 16'h1234;
    done = 1'b1;
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 16'h1234);
    chk("lat_tag", out_tag, 0);
    step();
    step();
    chk("held_one_cap", count, 1);
    done = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Five captures into four slots, then drain.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 1; i <= 5; i++) capture(WIDTH'(i));
    chk("ovf_full", full, 1);
    chk("ovf_sticky", overflow, 1);
`ifdef RESULT_BUF_OVF_CNT_EN
    chk("ovf_cnt_one", ovf_count, 1);
`endif
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", out_data, i);
      chk("drain_tag", out_tag, i - 1);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", empty, 1);

    // Capture coincident with a pop at full is accepted.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) capture(WIDTH'(16'h10 + i));
    r_in = 16'h00AA;
    done = 1'b1;
    out_ready = 1'b1;
    step();
    chk("full_pop_count", count, 4);
    chk("full_pop_ovf", overflow, 0);
    done = 1'b0;
    repeat (3) step();
    chk("full_pop_tag", out_tag, 4);
    chk("full_pop_data", out_data, 16'h00AA);
    step();
    out_ready = 1'b0;

    // Tag wrap over 260 capture/pop pairs.
    clear = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      r_in = WIDTH'($urandom);
      done = 1'b1;
      step();
      chk("wrap_tag", out_tag, i % 256);
      chk("wrap_cnt_le1", count <= 1, 1);
      done = 1'b0;
      step();
      chk("wrap_cnt_le1", count <= 1, 1);
    end
    out_ready = 1'b0;

    // Clear wins over a coincident capture.
    clear = 1'b1;
    step();
    clear = 1'b0;
    capture(16'h0001);
    capture(16'h0002);
    chk("pre_clear_cnt", count, 2);
    clear = 1'b1;
    r_in  = 16'hBEEF;
    done  = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_ovf", overflow, 0);
    step();
    chk("clr_held_done", count, 0);
    done = 1'b0;
    step();
    r_in = 16'h0007;
    done = 1'b1;
    step();
    chk("clr_next_tag", out_tag, 0);
    chk("clr_next_data", out_data, 16'h0007);
    done = 1'b0;
    step();

    // Random traffic: congested first half, draining second half.
    for (int i = 0; i < 600; i++) begin
      done      = 1'($urandom_range(0, 1));
      r_in      = WIDTH'($urandom);
      out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      step();
    end
    clear     = 1'b0;
    out_ready = 1'b0;
    done      = 1'b0;
    step();

    // Asynchronous reset mid-operation.
    capture(16'h0033);
    capture(16'h0044);
    chk("pre_arst_cnt", count, 2);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_count", count, 0);
    chk("arst_valid", out_valid, 0);
    check_model();
    step();
    rst = 1'b1;
    step();
    capture(16'h0055);
    chk("post_arst_tag", out_tag, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
